// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and constants for the runtime clock-divider controller.
//   clk_div_state_t     : controller FSM state (IDLE, RUN)
//   CLK_DIV_CNT_W       : default counter / divisor width
//   CLK_DIV_DEF_DIVISOR : default divisor loaded at reset (100 MHz -> 1 Hz)
// -----------------------------------------------------------------------------
package clk_div_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } clk_div_state_t;

   localparam int          CLK_DIV_CNT_W       = 32;
   localparam int unsigned CLK_DIV_DEF_DIVISOR = 50000000;

endpackage

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
// Period counter, terminal-count compare and square-wave toggle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   run       : counting enabled this cycle (low -> counter held at 0)
//   clr       : restart the period (counter to 0, no terminal count)
//   out_clr   : force clk_out low (run aborted or one-shot finished)
//   div       : active divisor (never 0)
//   term      : combinational terminal-count strobe (wrap this edge)
//   clk_out   : registered square wave, toggles on every wrap
// -----------------------------------------------------------------------------
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int CNT_W = CLK_DIV_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             clr,
   input  logic             out_clr,
   input  logic [CNT_W-1:0] div,
   output logic             term,
   output logic             clk_out
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_clk_out;
   logic             w_term;

   // A restart in the same cycle as a would-be wrap suppresses the wrap.
   assign w_term = run && !clr && (r_cnt == (div - CNT_W'(1)));

   always_ff @(posedge clk) begin
      if (rst || clr || !run) begin
         r_cnt <= '0;
      end else if (w_term) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Forcing low takes priority over the toggle so a one-shot ends at 0.
   always_ff @(posedge clk) begin
      if (rst || out_clr) begin
         r_clk_out <= 1'b0;
      end else if (w_term) begin
         r_clk_out <= ~r_clk_out;
      end
   end

   assign term    = w_term;
   assign clk_out = r_clk_out;

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Runtime controller for the counter-based clock divider: start/stop,
// one-shot or continuous runs, and glitch-free divisor updates through a
// valid/ready handshake (applied at a period boundary while running).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin / restart a run (pulse)
//   stop         : abort the run (pulse, wins over start)
//   oneshot      : sampled with start; stop after the first tick
//   cfg_valid    : divisor update offered
//   cfg_divisor  : new divisor (0 is treated as 1)
//   cfg_ready    : controller can accept a divisor (combinational)
//   tick         : one-cycle pulse per completed period
//   clk_out      : square wave toggling on every tick
//   busy         : high while running
//   done         : one-cycle pulse when a one-shot run completes
//   tick_count   : 16-bit wrapping tick counter, present only when
//                  CLK_DIV_CTRL_TICK_CNT_EN is defined
// -----------------------------------------------------------------------------
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int          CNT_W       = CLK_DIV_CNT_W,
   parameter int unsigned DEF_DIVISOR = CLK_DIV_DEF_DIVISOR
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             oneshot,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_divisor,
   output logic             cfg_ready,
   output logic             tick,
   output logic             clk_out,
   output logic             busy,
   output logic             done
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
   ,
   output logic [15:0]      tick_count
`endif
);

   localparam logic [CNT_W-1:0] DEF_DIV_C =
      (DEF_DIVISOR == 0) ? CNT_W'(1) : CNT_W'(DEF_DIVISOR);

   clk_div_state_t   r_state;
   clk_div_state_t   w_state_next;
   logic [CNT_W-1:0] r_div_q;
   logic [CNT_W-1:0] r_div_sh;
   logic             r_pend;
   logic             r_oneshot;
   logic             r_tick;
   logic             r_done;

   logic             w_start_ok;
   logic             w_run;
   logic             w_term;
   logic             w_done_evt;
   logic             w_exit_run;
   logic             w_xfer;
   logic [CNT_W-1:0] w_div_in;
   logic             w_cfg_ready;
   logic             w_busy;

   assign w_start_ok = start && !stop;
   assign w_run      = (r_state == RUN) && !stop;
   assign w_done_evt = w_term && r_oneshot;
   assign w_exit_run = (r_state == RUN) && (stop || w_done_evt);
   assign w_xfer     = cfg_valid && w_cfg_ready;
   assign w_div_in   = (cfg_divisor == '0) ? CNT_W'(1) : cfg_divisor;

   // --------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_start_ok) begin
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               w_state_next = IDLE;
            end else if (start) begin
               w_state_next = RUN;
            end else if (w_done_evt) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // cfg_ready is gated by rst so nothing is accepted during reset.
   always_comb begin
      w_cfg_ready = !rst && ((r_state == IDLE) || !r_pend);
      w_busy      = (r_state == RUN);
   end

   // ---------------------------------------------- divisor / handshake
   // In IDLE a transfer goes straight to div_q. In RUN it parks in the
   // shadow and is applied at the next wrap, or on the way back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_q   <= DEF_DIV_C;
         r_div_sh  <= DEF_DIV_C;
         r_pend    <= 1'b0;
         r_oneshot <= 1'b0;
         r_tick    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_tick <= w_term;
         r_done <= w_done_evt;
         if (w_start_ok) begin
            r_oneshot <= oneshot;
         end
         if (r_state == IDLE) begin
            if (w_xfer) begin
               r_div_q <= w_div_in;
            end
         end else if (w_exit_run) begin
            // A transfer is only possible here when nothing was pending,
            // so the offered value is the newest one.
            if (w_xfer) begin
               r_div_q <= w_div_in;
            end else if (r_pend) begin
               r_div_q <= r_div_sh;
            end
            r_pend <= 1'b0;
         end else if (w_term && r_pend) begin
            r_div_q <= r_div_sh;
            r_pend  <= 1'b0;
         end else if (w_xfer) begin
            r_div_sh <= w_div_in;
            r_pend   <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------ core
   clk_div_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .run     (w_run),
      .clr     (w_start_ok),
      .out_clr (w_exit_run),
      .div     (r_div_q),
      .term    (w_term),
      .clk_out (clk_out)
   );

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
   logic [15:0] r_tick_cnt;

   // Cleared only when a run actually begins from IDLE; held through stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else if ((r_state == IDLE) && w_start_ok) begin
         r_tick_cnt <= '0;
      end else if (w_term) begin
         r_tick_cnt <= r_tick_cnt + 16'd1;
      end
   end

   assign tick_count = r_tick_cnt;
`endif

   assign cfg_ready = w_cfg_ready;
   assign tick      = r_tick;
   assign busy      = w_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Directed bench for clk_div_ctrl with DEF_DIVISOR = 4. Expected ticks are
// queued (absolute cycle, clk_out, done) when a run is launched and popped
// as the DUT pulses tick. Optional tick counter checks follow
// CLK_DIV_CTRL_TICK_CNT_EN.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

   localparam int CNT_W = 32;

   typedef struct {
      int   cyc;
      logic co;
      logic dn;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic             stop;
   logic             oneshot;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_divisor;
   logic             cfg_ready;
   logic             tick;
   logic             clk_out;
   logic             busy;
   logic             done;
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
   logic [15:0]      tick_count;
`endif

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   t0;
   exp_t exp_q[$];

   clk_div_ctrl #(
      .CNT_W       (CNT_W),
      .DEF_DIVISOR (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .oneshot     (oneshot),
      .cfg_valid   (cfg_valid),
      .cfg_divisor (cfg_divisor),
      .cfg_ready   (cfg_ready),
      .tick        (tick),
      .clk_out     (clk_out),
      .busy        (busy),
      .done        (done)
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
      ,
      .tick_count  (tick_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, expv, cyc);
      end
   endtask

   task automatic push_tick(input int c, input logic co, input logic dn);
      exp_t e;
      e.cyc = c;
      e.co  = co;
      e.dn  = dn;
      exp_q.push_back(e);
   endtask

   task automatic check_tick();
      exp_t e;
      if (tick === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_tick", 32'(tick), 32'd0);
         end else begin
            e = exp_q.pop_front();
            $display("tick at cyc=%0d clk_out=%0b done=%0b (expected cyc=%0d)", cyc, clk_out, done, e.cyc);
            chk("tick_cycle", cyc, e.cyc);
            chk("tick_clk_out", 32'(clk_out), 32'(e.co));
            chk("tick_done", 32'(done), 32'(e.dn));
         end
      end else begin
         chk("done_without_tick", 32'(done), 32'd0);
         if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("missing_tick", 32'(tick), 32'd1);
         end
      end
   endtask

   // Advance one edge, then sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      check_tick();
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      stop        = 1'b0;
      oneshot     = 1'b0;
      cfg_valid   = 1'b0;
      cfg_divisor = '0;

      // ---------------- reset values
      step();
      step();
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_clk_out", 32'(clk_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
      chk("rst_tick_count", 32'(tick_count), 32'd0);
`endif
      rst = 1'b0;
      step();
      chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);

      // ---------------- continuous run at the reset divisor (4)
      start = 1'b1;
      push_tick(cyc + 1 + 4, 1'b1, 1'b0);
      push_tick(cyc + 1 + 8, 1'b0, 1'b0);
      push_tick(cyc + 1 + 12, 1'b1, 1'b0);
      step();
      start = 1'b0;
      chk("run_busy", 32'(busy), 32'd1);
      repeat (12) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_clk_out", 32'(clk_out), 32'd0);
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
      chk("tick_count_3", 32'(tick_count), 32'd3);
`endif
      repeat (3) step();
      chk("s1_queue_empty", exp_q.size(), 0);

      // ---------------- divisor 4 -> 6 while running
      start = 1'b1;
      t0 = cyc + 1;
      push_tick(t0 + 4, 1'b1, 1'b0);
      push_tick(t0 + 10, 1'b0, 1'b0);
      step();
      start = 1'b0;
      step();                                  // rel 1
      chk("run_ready_before_cfg", 32'(cfg_ready), 32'd1);
      cfg_valid   = 1'b1;
      cfg_divisor = 32'd6;
      step();                                  // rel 2: transfer edge
      cfg_valid = 1'b0;
      chk("pend_ready_rel2", 32'(cfg_ready), 32'd0);
      step();                                  // rel 3
      chk("pend_ready_rel3", 32'(cfg_ready), 32'd0);
      step();                                  // rel 4: wrap applies 6
      chk("ready_after_wrap", 32'(cfg_ready), 32'd1);
      repeat (11) step();                      // rel 15
      stop = 1'b1;                             // lands on the rel-16 wrap
      step();
      stop = 1'b0;
      chk("stop_at_wrap_busy", 32'(busy), 32'd0);
      repeat (3) step();
      chk("s2_queue_empty", exp_q.size(), 0);

      // ---------------- one-shot at divisor 3
      cfg_valid   = 1'b1;
      cfg_divisor = 32'd3;
      step();
      cfg_valid = 1'b0;
      start     = 1'b1;
      oneshot   = 1'b1;
      push_tick(cyc + 1 + 3, 1'b0, 1'b1);
      step();
      start   = 1'b0;
      oneshot = 1'b0;
      chk("oneshot_busy", 32'(busy), 32'd1);
      repeat (3) step();
      chk("oneshot_busy_fall", 32'(busy), 32'd0);
      repeat (6) step();
      chk("s3_queue_empty", exp_q.size(), 0);

      // ---------------- stop+start together, then restart-in-RUN
      start = 1'b1;
      push_tick(cyc + 1 + 3, 1'b1, 1'b0);
      step();
      start = 1'b0;
      repeat (4) step();
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("stop_start_busy", 32'(busy), 32'd0);
      chk("stop_start_clk_out", 32'(clk_out), 32'd0);
      repeat (2) step();
      start = 1'b1;
      t0 = cyc + 1;
      push_tick(t0 + 3, 1'b1, 1'b0);
      push_tick(t0 + 6, 1'b0, 1'b0);
      push_tick(t0 + 11, 1'b1, 1'b0);
      push_tick(t0 + 14, 1'b0, 1'b0);
      step();
      start = 1'b0;
      repeat (7) step();                       // rel 7
      start = 1'b1;                            // restart at rel-8 edge
      step();
      start = 1'b0;
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_clk_out_held", 32'(clk_out), 32'd0);
      repeat (6) step();                       // rel 14
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("s4_queue_empty", exp_q.size(), 0);

      // ---------------- divisor 0 (clamped to 1) with start in the same cycle
      cfg_valid   = 1'b1;
      cfg_divisor = 32'd0;
      start       = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         push_tick(cyc + 1 + k, logic'(k % 2), 1'b0);
      end
      step();
      cfg_valid = 1'b0;
      start     = 1'b0;
      repeat (6) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("div1_stop_clk_out", 32'(clk_out), 32'd0);
      chk("s5_queue_empty", exp_q.size(), 0);

      // ---------------- reset during a run with a pending divisor
      cfg_valid   = 1'b1;
      cfg_divisor = 32'd2;
      step();
      cfg_valid = 1'b0;
      start     = 1'b1;
      push_tick(cyc + 1 + 2, 1'b1, 1'b0);
      step();
      start = 1'b0;
      step();
      step();                                  // rel 2 tick
      cfg_valid   = 1'b1;
      cfg_divisor = 32'd7;
      step();
      cfg_valid = 1'b0;
      chk("pend_before_rst", 32'(cfg_ready), 32'd0);
      rst = 1'b1;
      step();
      chk("midrst_tick", 32'(tick), 32'd0);
      chk("midrst_clk_out", 32'(clk_out), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
      chk("midrst_tick_count", 32'(tick_count), 32'd0);
`endif
      rst = 1'b0;
      step();
      chk("post_rst_ready", 32'(cfg_ready), 32'd1);
      start = 1'b1;
      push_tick(cyc + 1 + 4, 1'b1, 1'b0);
      push_tick(cyc + 1 + 8, 1'b0, 1'b0);
      step();
      start = 1'b0;
      repeat (8) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      repeat (2) step();
      chk("s6_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
